// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative HI/LO multiply/divide unit for the single-issue MIPS datapath.
//   Executes MULTU/MULT (shift-add) and DIVU/DIV (restoring) one bit per cycle
//   into private HI/LO registers; MTHI/MTLO write them directly while idle.
//   An operation takes DATA_WIDTH+1 edges from acceptance to HI/LO update.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   Start_i        start request (sampled only in IDLE)
//   Op_i           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   Operand_A_i    rs value: multiplicand / dividend / MTHI-MTLO source
//   Operand_B_i    rt value: multiplier / divisor
//   Mthi_i         write Operand_A_i into HI (IDLE only, Start_i has priority)
//   Mtlo_i         write Operand_A_i into LO (IDLE only, Start_i has priority)
//   Busy_o         operation in flight
//   Done_o         one-cycle pulse when an operation has updated HI/LO
//   Div_By_Zero_o  one-cycle pulse with Done_o for a divide with B=0
//   Hi_o, Lo_o     HI/LO registers
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic [1:0]            Op_i,
  input  logic [DATA_WIDTH-1:0] Operand_A_i,
  input  logic [DATA_WIDTH-1:0] Operand_B_i,
  input  logic                  Mthi_i,
  input  logic                  Mtlo_i,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic                  Div_By_Zero_o,
  output logic [DATA_WIDTH-1:0] Hi_o,
  output logic [DATA_WIDTH-1:0] Lo_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_mag_a;
  logic [W-1:0]    r_mag_b;
  logic [W-1:0]    r_orig_a;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic [2*W-1:0]  r_acc;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_is_div;
  logic            r_done;
  logic            r_dbz;

  logic            w_last;
  logic            w_signed;
  logic [W-1:0]    w_abs_a;
  logic [W-1:0]    w_abs_b;
  logic [W:0]      w_mul_sum;
  logic [W:0]      w_rem_sh;
  logic [W+1:0]    w_diff;
  logic            w_qbit;
  logic [W-1:0]    w_rem_next;
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_quot;
  logic [W-1:0]    w_rem;

  // Accumulator layout
  //   multiply: acc = {partial product high, multiplier bits still to consume};
  //             each step adds the multiplicand to the top half and shifts right.
  //   divide:   acc = {partial remainder, dividend bits / quotient bits};
  //             each step shifts left one bit and trial-subtracts the divisor.
  always_comb begin
    w_signed   = Op_i[0];
    w_abs_a    = (w_signed && Operand_A_i[W-1]) ? -Operand_A_i : Operand_A_i;
    w_abs_b    = (w_signed && Operand_B_i[W-1]) ? -Operand_B_i : Operand_B_i;
    w_last     = (r_cnt == CW'(W-1));

    w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_mag_a : {W{1'b0}})};

    w_rem_sh   = r_acc[2*W-1:W-1];
    w_diff     = {1'b0, w_rem_sh} - {2'b00, r_mag_b};
    w_qbit     = ~w_diff[W+1];
    w_rem_next = w_qbit ? w_diff[W-1:0] : w_rem_sh[W-1:0];

    w_prod     = r_neg_q ? -r_acc : r_acc;
    w_quot     = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    w_rem      = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Start_i) w_next = Op_i[1] ? S_DIV : S_MUL;
      S_MUL:   if (w_last)  w_next = S_FIX;
      S_DIV:   if (w_last)  w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_orig_a <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start_i) begin
            r_mag_a  <= w_abs_a;
            r_mag_b  <= w_abs_b;
            r_orig_a <= Operand_A_i;
            r_neg_q  <= w_signed & (Operand_A_i[W-1] ^ Operand_B_i[W-1]);
            r_neg_r  <= w_signed & Operand_A_i[W-1];
            r_is_div <= Op_i[1];
            r_acc    <= Op_i[1] ? {{W{1'b0}}, w_abs_a} : {{W{1'b0}}, w_abs_b};
            r_cnt    <= '0;
          end else begin
            if (Mthi_i) r_hi <= Operand_A_i;
            if (Mtlo_i) r_lo <= Operand_A_i;
          end
        end
        S_MUL: begin
          r_acc <= {w_mul_sum, r_acc[W-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_DIV: begin
          r_acc <= {w_rem_next, r_acc[W-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            if (r_mag_b == '0) begin
              r_hi  <= r_orig_a;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
          end else begin
            r_hi <= w_prod[2*W-1:W];
            r_lo <= w_prod[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy_o        = (r_state != S_IDLE);
  assign Done_o        = r_done;
  assign Div_By_Zero_o = r_dbz;
  assign Hi_o          = r_hi;
  assign Lo_o          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit. A behavioural model computes the
//   HI/LO result of each accepted operation with plain 64-bit arithmetic and
//   releases it DATA_WIDTH+1 edges later; outputs are compared every cycle on
//   the falling edge. Directed operations also check hand-computed literals.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         Start_i = 1'b0;
  logic [1:0]   Op_i = 2'b00;
  logic [W-1:0] Operand_A_i = '0;
  logic [W-1:0] Operand_B_i = '0;
  logic         Mthi_i = 1'b0;
  logic         Mtlo_i = 1'b0;
  logic         Busy_o;
  logic         Done_o;
  logic         Div_By_Zero_o;
  logic [W-1:0] Hi_o;
  logic [W-1:0] Lo_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .Start_i       (Start_i),
    .Op_i          (Op_i),
    .Operand_A_i   (Operand_A_i),
    .Operand_B_i   (Operand_B_i),
    .Mthi_i        (Mthi_i),
    .Mtlo_i        (Mtlo_i),
    .Busy_o        (Busy_o),
    .Done_o        (Done_o),
    .Div_By_Zero_o (Div_By_Zero_o),
    .Hi_o          (Hi_o),
    .Lo_o          (Lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: {div_by_zero, HI, LO}
  function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      2'd0: p = {32'b0, a} * {32'b0, b};
      2'd1: p = 64'(sa * sb);
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        if (op == 2'd2) p = {a % b, a / b};
        else begin
          p[31:0]  = 32'(sa / sb);
          p[63:32] = 32'(sa % sb);
        end
      end
    endcase
    return {1'b0, p};
  endfunction

  // Behavioural model state
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  int           m_left = 0;
  logic [63:0]  m_res = '0;
  logic         m_res_dbz = 1'b0;
  logic [64:0]  m_r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_dbz  = m_res_dbz;
          {m_hi, m_lo} = m_res;
        end
      end else if (Start_i) begin
        m_r       = ref_op(Op_i, Operand_A_i, Operand_B_i);
        m_res     = m_r[63:0];
        m_res_dbz = m_r[64];
        m_busy    = 1'b1;
        m_left    = W + 1;
      end else begin
        if (Mthi_i) m_hi = Operand_A_i;
        if (Mtlo_i) m_lo = Operand_A_i;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 64'(Busy_o), 64'(m_busy));
      chk("cyc_done", 64'(Done_o), 64'(m_done));
      chk("cyc_dbz",  64'(Div_By_Zero_o), 64'(m_dbz));
      chk("cyc_hi",   64'(Hi_o), 64'(m_hi));
      chk("cyc_lo",   64'(Lo_o), 64'(m_lo));
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one operation at #1 after an edge and wait (bounded) for Done_o.
  // inj >= 0: at that busy cycle drive a competing DIVU start plus MTHI.
  // mv: drive MTHI/MTLO together with the start (start must win).
  task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic edbz, input int inj,
                        input bit mv);
    int cyc, busy_n;
    bit got;
    logic [W-1:0] hi_before;
    @(posedge clk); #1;
    hi_before = Hi_o;
    Start_i = 1'b1; Op_i = op; Operand_A_i = a; Operand_B_i = b;
    Mthi_i = mv; Mtlo_i = mv;
    @(posedge clk); #1;
    Start_i = 1'b0; Mthi_i = 1'b0; Mtlo_i = 1'b0;
    Operand_A_i = 32'($urandom); Operand_B_i = 32'($urandom);
    if (mv) chk({nm, "_start_wins"}, 64'(Hi_o), 64'(hi_before));
    cyc = 0; busy_n = 0; got = 0;
    while (cyc < 40 && !got) begin
      if (Busy_o) busy_n++;
      if (cyc == inj) begin
        Start_i = 1'b1; Op_i = 2'd2; Mthi_i = 1'b1; Operand_A_i = 32'h0BAD0BAD;
      end else begin
        Start_i = 1'b0; Mthi_i = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (Done_o) got = 1;
    end
    Start_i = 1'b0; Mthi_i = 1'b0;
    chk({nm, "_latency"}, 64'(cyc), 64'(W + 1));
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(W + 1));
    chk({nm, "_hi"}, 64'(Hi_o), 64'(ehi));
    chk({nm, "_lo"}, 64'(Lo_o), 64'(elo));
    chk({nm, "_dbz"}, 64'(Div_By_Zero_o), 64'(edbz));
  endtask

  initial begin
    int dones;
    #2 reset = 1'b1;
    #1;
    chk("rst_hi", 64'(Hi_o), 64'h0);
    chk("rst_lo", 64'(Lo_o), 64'h0);
    chk("rst_busy", 64'(Busy_o), 64'h0);
    chk("rst_done", 64'(Done_o), 64'h0);
    chk("rst_dbz", 64'(Div_By_Zero_o), 64'h0);
    chk_en = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    run_op("multu_max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, -1, 1'b0);
    run_op("mult_neg",  2'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, -1, 1'b0);
    run_op("div_neg",   2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, -1, 1'b0);
    run_op("div_ovf",   2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, -1, 1'b0);
    run_op("divu_zero", 2'd2, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, -1, 1'b0);
    run_op("div_zero_s",2'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, -1, 1'b0);
    run_op("busy_ign",  2'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 5, 1'b0);

    Mthi_i = 1'b1; Mtlo_i = 1'b1; Operand_A_i = 32'h12345678;
    @(posedge clk); #1;
    Mthi_i = 1'b0; Mtlo_i = 1'b0;
    chk("mv_hi", 64'(Hi_o), 64'h12345678);
    chk("mv_lo", 64'(Lo_o), 64'h12345678);

    run_op("start_mv",  2'd0, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0, -1, 1'b1);

    // Reset in the middle of a DIV
    @(posedge clk); #1;
    Start_i = 1'b1; Op_i = 2'd3; Operand_A_i = 32'hFFFFFF00; Operand_B_i = 32'h7;
    @(posedge clk); #1;
    Start_i = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_hi", 64'(Hi_o), 64'h0);
    chk("midrst_lo", 64'(Lo_o), 64'h0);
    chk("midrst_busy", 64'(Busy_o), 64'h0);
    @(posedge clk); #1 reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done_o) dones++;
    end
    chk("midrst_no_done", 64'(dones), 64'h0);
    run_op("post_rst", 2'd0, 32'h3, 32'h4, 32'h0, 32'd12, 1'b0, -1, 1'b0);

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      Start_i     = ($urandom_range(0, 7) == 0);
      Op_i        = 2'($urandom);
      Operand_A_i = pick();
      Operand_B_i = pick();
      Mthi_i      = ($urandom_range(0, 3) == 0);
      Mtlo_i      = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    Start_i = 1'b0; Mthi_i = 1'b0; Mtlo_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("final_idle", 64'(Busy_o), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
